// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side blocks: data width and
// the capture FSM state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } cap_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 byte storage for the receive FIFO: synchronous write port and a
// registered read port. The read register is reset; the array is not.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [UART_DATA_W-1:0] wdata,
    input  logic                   re,
    input  logic [ADDR_W-1:0]      raddr,
    output logic [UART_DATA_W-1:0] rdata
);

    logic [UART_DATA_W-1:0] mem [DEPTH];

    // Store the incoming byte; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; a same-edge write to the same slot returns the old byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: captures each ready byte,
// acknowledges it with a one-cycle rx_clr pulse, and buffers it for the host.
// Optional feature macro UART_RX_FIFO_ALMOST_FULL_EN adds AF_LEVEL and a
// registered almost_full output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    , parameter int AF_LEVEL = DEPTH - 2
`endif
    , localparam int ADDR_W = $clog2(DEPTH)
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rx_ready,
    output logic                   rx_clr,
    input  logic                   rd_en,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [ADDR_W:0]        count,
    output logic                   overrun,
    input  logic                   clr_overrun
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    , output logic                 almost_full
`endif
);

    cap_state_t        state, next_state;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              rd_accept, wr_allow, capture, wr_en, drop;

    assign empty     = (count == '0);
    assign full      = (count == (ADDR_W+1)'(DEPTH));
    assign rd_accept = rd_en && !empty;
    assign wr_allow  = !full || rd_accept;
    assign capture   = (state == IDLE) && rx_ready;
    assign wr_en     = capture && wr_allow;
    assign drop      = capture && !wr_allow;

    // Capture FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: capture once, acknowledge, then wait for ready to fall.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (rx_ready) next_state = ACK;
            ACK:      next_state = WAIT_LOW;
            WAIT_LOW: if (!rx_ready) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // rx_clr is registered so it is high exactly while the FSM sits in ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_clr <= 1'b0;
        end else begin
            rx_clr <= (next_state == ACK);
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_accept) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_en, rd_accept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Read strobe follows an accepted read by one cycle, aligned with rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
        end
    end

    // Sticky overrun: a dropped byte sets it and beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    // Early flow warning, one cycle behind count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (int'(count) >= AF_LEVEL);
        end
    end
`endif

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .re    (rd_accept),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH = 16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_clr;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       clr_overrun;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    logic       almost_full;
`endif

    int total = 0;
    int bad   = 0;

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_clr      (rx_clr),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
        , .almost_full (almost_full)
`endif
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present one byte as the receiver would, optionally with a host read in
    // the capture cycle; returns what the read strobe/data showed after it.
    task automatic applyStimulus(input logic [7:0] b, input bit withRead,
                                 output logic rdv, output logic [7:0] rdd);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        rd_en    = withRead;
        @(negedge clk);
        rd_en = 1'b0;
        rdv   = rd_valid;
        rdd   = rd_data;
        checkOutput("clr_high", rx_clr, 1);
        @(negedge clk);
        checkOutput("clr_one_cycle", rx_clr, 0);
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    // Host read of one byte with a known expected value.
    task automatic readByte(input string tag, input logic [7:0] exp);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checkOutput({tag, "_valid"}, rd_valid, 1);
        checkOutput(tag, rd_data, exp);
    endtask

    initial begin
        logic       v;
        logic [7:0] d;

        rst_n       = 1'b0;
        rx_data     = 8'h00;
        rx_ready    = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        #12;
        checkOutput("rst_count", count, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_clr", rx_clr, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_rd_data", rd_data, 8'h00);
        checkOutput("rst_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        $display("[TB] single byte");
        applyStimulus(8'hA5, 1'b0, v, d);
        checkOutput("single_count", count, 1);
        checkOutput("single_empty", empty, 0);
        readByte("single_rd", 8'hA5);
        checkOutput("single_empty_after", empty, 1);
        checkOutput("single_count_after", count, 0);

        $display("[TB] fill and wrap");
        for (int i = 0; i < 16; i++) begin
            if (i == 15) checkOutput("fill_not_full_15", full, 0);
            applyStimulus(8'(i), 1'b0, v, d);
        end
        checkOutput("fill_full", full, 1);
        checkOutput("fill_count", count, 16);
        for (int i = 0; i < 8; i++) readByte("wrap_rd_a", 8'(i));
        checkOutput("wrap_count_8", count, 8);
        for (int i = 16; i < 24; i++) applyStimulus(8'(i), 1'b0, v, d);
        checkOutput("wrap_full", full, 1);
        for (int i = 8; i < 24; i++) readByte("wrap_rd_b", 8'(i));
        checkOutput("wrap_empty", empty, 1);

        $display("[TB] overrun");
        for (int i = 0; i < 16; i++) applyStimulus(8'h20 + 8'(i), 1'b0, v, d);
        applyStimulus(8'hEE, 1'b0, v, d);
        checkOutput("ovr_count", count, 16);
        checkOutput("ovr_flag", overrun, 1);
        readByte("ovr_oldest", 8'h20);
        checkOutput("ovr_still_set", overrun, 1);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        checkOutput("ovr_cleared", overrun, 0);

        $display("[TB] simultaneous read and write at full");
        applyStimulus(8'h30, 1'b0, v, d);
        checkOutput("sim_pre_full", full, 1);
        applyStimulus(8'h55, 1'b1, v, d);
        checkOutput("sim_rd_valid", v, 1);
        checkOutput("sim_rd_data", d, 8'h21);
        checkOutput("sim_count", count, 16);
        checkOutput("sim_overrun", overrun, 0);
        for (int i = 2; i < 16; i++) readByte("sim_drain", 8'h20 + 8'(i));
        readByte("sim_drain_30", 8'h30);
        readByte("sim_last_55", 8'h55);
        checkOutput("sim_empty", empty, 1);

        $display("[TB] empty read");
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checkOutput("empty_rd_valid", rd_valid, 0);
        checkOutput("empty_rd_data", rd_data, 8'h55);
        checkOutput("empty_count", count, 0);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 4; i++) applyStimulus(8'h61 + 8'(i), 1'b0, v, d);
        @(negedge clk);
        rx_data  = 8'h65;
        rx_ready = 1'b1;
        @(negedge clk);
        checkOutput("rmid_in_ack", rx_clr, 1);
        checkOutput("rmid_count5", count, 5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rmid_clr", rx_clr, 0);
        checkOutput("rmid_count", count, 0);
        checkOutput("rmid_empty", empty, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rmid_recapture_clr", rx_clr, 1);
        checkOutput("rmid_recapture_count", count, 1);
        @(negedge clk);
        checkOutput("rmid_clr_drop", rx_clr, 0);
        rx_ready = 1'b0;
        readByte("rmid_rd", 8'h65);
        checkOutput("rmid_empty_after", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver.
- Each byte is captured while the receiver's data_ready is high. The receiver's clr_ready is then pulsed for exactly one cycle.
- Bytes are stored in a DEPTH-entry circular FIFO, so the host can drain them at its own pace.
- Reports occupancy and a sticky overrun flag when bytes arrive with the FIFO full.

Parameters:
- DEPTH, 16, number of byte entries; power of two, 2..256.
- ADDR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  in  1  system clock, same clock as the baud generator and UART.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from the receiver's data_out.
- rx_ready  in  1  receiver's data_ready; level, held until cleared.
- rx_clr  out  1  to the receiver's clr_ready; one-cycle pulse.
- rd_en  in  1  host read request.
- rd_data  out  8  registered read data.
- rd_valid  out  1  one-cycle pulse; rd_data is valid in this cycle.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  ADDR_W+1  current occupancy.
- overrun  out  1  sticky: a byte was dropped.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset (async assert, sync release): wr_ptr = rd_ptr = 0, count = 0, state = IDLE, rx_clr = 0, rd_data = 0x00, rd_valid = 0, overrun = 0, empty = 1, full = 0. Memory contents are not reset.
- Capture FSM, three states:
  - IDLE: when rx_ready = 1, go to ACK.
    - If a write is allowed, write rx_data at wr_ptr in that same cycle.
    - Otherwise drop the byte and set overrun.
  - ACK: rx_clr = 1 for this single cycle; go to WAIT_LOW.
  - WAIT_LOW: stay until rx_ready = 0, then go to IDLE. This guards against double capture of one byte.
- rx_clr is a registered output and is high only in the ACK state.
- Write allowed: (!full) OR (an accepted read in the same cycle).
- Read:
  - Accepted when rd_en = 1 and !empty.
  - rd_data is loaded from mem[rd_ptr] at the next edge, and rd_valid pulses that cycle.
  - Read latency is 1 clock.
  - rd_en while empty is ignored: no pointer change, rd_valid = 0, rd_data holds.
- Pointers are ADDR_W bits and wrap modulo DEPTH with no special case.
- count:
  - +1 on a write only.
  - -1 on a read only.
  - Unchanged on a simultaneous write and read, including when full: the read of the oldest entry and the write of the new byte both succeed.
- empty and full are combinational from count.
- overrun:
  - Set on a dropped byte.
  - Cleared by clr_overrun.
  - If set and clear happen in the same cycle, set wins.
- Write-to-read visibility: a byte written at edge N can be read by an rd_en sampled at edge N+1 at the earliest.
- Reset mid-frame: the FSM returns to IDLE. If the receiver still holds rx_ready = 1 after reset, that byte is captured normally.

Optional Feature:
- Macro: UART_RX_FIFO_ALMOST_FULL_EN.
- When defined, adds a parameter and a port:
  - Parameter AF_LEVEL, default DEPTH-2.
  - Output almost_full, 1 bit: registered, high when count >= AF_LEVEL, reset 0, updated one cycle after count changes. Used for host-side flow warning.
- When undefined: no almost_full port, no AF_LEVEL parameter, no extra logic.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W = 8.
  - Capture FSM state typedef: IDLE = 2'd0, ACK = 2'd1, WAIT_LOW = 2'd2.
- One natural sub-module, uart_fifo_mem:
  - DEPTH x 8 storage.
  - Synchronous write port (we, waddr, wdata).
  - Registered read port (re, raddr, rdata).
  - Pointers, count and flags stay in uart_rx_fifo.

Test Plan:
- Single byte:
  - Stimulus: rx_data = 0xA5, rx_ready high from cycle 10, dropped 2 cycles after rx_clr.
  - Required: rx_clr is high exactly 1 cycle, at cycle 12; count = 1; a later rd_en gives rd_data = 0xA5 with rd_valid 1 cycle later; empty = 1 afterwards.
- Fill and wrap:
  - Stimulus: write 0x00..0x0F (DEPTH = 16), then read 8, write 0x10..0x17, then read all.
  - Required: full = 1 after the 16th byte; the read order is 0x00..0x17 exactly.
- Overrun:
  - Stimulus: with full = 1 and no read, present 0xEE.
  - Required: rx_clr still pulses; count stays 16; overrun = 1; the next read returns the oldest byte, not 0xEE; clr_overrun clears the flag.
- Simultaneous read and write at full:
  - Stimulus: rd_en asserted in the same cycle as the IDLE capture of 0x55.
  - Required: count stays 16, overrun = 0, and 0x55 is the last byte read out.
- Empty read:
  - Stimulus: rd_en pulsed with count = 0.
  - Required: rd_valid = 0, rd_data unchanged, count = 0.
- Reset mid-operation:
  - Stimulus: assert rst_n = 0 while in ACK with count = 5.
  - Required: rx_clr = 0, count = 0, and empty = 1 immediately (asynchronously); capture resumes after release.
